tohost_monitor: RTL and testbench
=================================

TOHOST_MONITOR -- requirements
Module: tohost_monitor

Interface
REQ-001 Parameters (name, default, meaning):
 - TOHOST_ADDR, 32'h8000_1000, word address of tohost.
 - FROMHOST_ADDR, 32'h8000_1040, word address of fromhost.
 - MAX_TICKS, 100000, RUN cycles before timeout.
REQ-002 Ports (name, direction, width, meaning):
 - clk_i, in, 1, sole clock.
 - rst_i, in, 1, synchronous active-high reset.
 - dmem_addr_i, in, 32, core data address.
 - dmem_read_i, in, 1, core read strobe.
 - dmem_wsel_byte_i, in, 4, byte write enables; any bit set = write.
 - dmem_wdata_i, in, 32, write data.
 - dmem_rdata_o, out, 32, registered read data.
 - hit_o, in/out direction out, 1, access decodes to tohost or fromhost this cycle; used by bench to mux rdata.
 - done_o, out, 1, terminal state reached.
 - pass_o, out, 1, terminal state is PASS.
 - timeout_o, out, 1, terminal state is TIMEOUT.
 - fail_code_o, out, 31, tohost[31:1] captured on FAIL (riscv-tests failing test number).
 - cycle_count_o, out, 32, cycles spent in RUN, saturating.

Function
REQ-003 Decode compares dmem_addr_i[31:2] against ADDR[31:2]; bits [1:0] ignored; hit_o combinational.
REQ-004 Writes update tohost/fromhost per byte lane at posedge; unselected lanes hold.
REQ-005 Read with dmem_read_i and hit: dmem_rdata_o = addressed register one cycle later (same 1-cycle latency as dp_mem); non-hit reads give 0 next cycle.
REQ-006 Read and write to same register in same cycle: read returns pre-write value.
REQ-007 FSM states IDLE, RUN, PASS, FAIL, TIMEOUT.
REQ-008 IDLE -> RUN unconditionally on the first cycle after rst_i deasserts.
REQ-009 In RUN, the cycle after a tohost write, the merged tohost value is evaluated: bit0=0 -> stay RUN; value==1 -> PASS; bit0=1 and value!=1 -> FAIL, fail_code_o <= value[31:1].
REQ-010 cycle_count_o increments every RUN cycle, saturates at 32'hFFFF_FFFF, frozen outside RUN.
REQ-011 RUN -> TIMEOUT when cycle_count_o == MAX_TICKS-1 and no terminating evaluation that cycle.
REQ-012 Simultaneous terminating evaluation and timeout: evaluation wins (PASS/FAIL).
REQ-013 PASS, FAIL, TIMEOUT sticky until rst_i; later writes still update registers but do not change state or fail_code_o.
REQ-014 done_o = state in {PASS, FAIL, TIMEOUT}; pass_o, timeout_o decoded from state, registered.

Reset
REQ-015 rst_i high at posedge: state IDLE, tohost 0, fromhost 0, dmem_rdata_o 0, fail_code_o 0, cycle_count_o 0, done_o/pass_o/timeout_o 0.
REQ-016 rst_i mid-RUN or in a terminal state aborts immediately; any write in the reset cycle is discarded.

Structure
REQ-017 Package tohost_pkg holds the state enum and default TOHOST/FROMHOST address constants.
REQ-018 Sub-module host_reg (32-bit byte-enabled register with sync reset) instantiated for tohost and fromhost; FSM and counter inline.

Verification
REQ-019 Write 32'h1 to 0x8000_1000 at cycle 50 -> done_o=1, pass_o=1 two cycles later; cycle_count_o frozen at ~51.
REQ-020 Write 32'h0000_0007 -> FAIL, fail_code_o=3, pass_o=0.
REQ-021 Byte writes: wsel 4'b0001 data 8'h00, then wsel 4'b0001 data 8'h01 -> stays RUN after first, PASS after second.
REQ-022 MAX_TICKS=20, no writes -> timeout_o=1 after 20 RUN cycles, count=19.
REQ-023 MAX_TICKS=20, write 32'h1 timed so evaluation coincides with count 19 -> PASS, timeout_o=0.
REQ-024 Write fromhost 32'hDEAD_BEEF, read back -> rdata 32'hDEAD_BEEF one cycle later; assert rst_i in PASS -> all outputs 0, RUN resumes.

Source files
------------

// File: rtl/tohost_pkg.sv
// ============================================================================
// Module  : tohost_pkg
// Brief   : Shared state encoding and default host-register addresses.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tohost_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam logic [31:0] c_TOHOST_ADDR_DFLT   = 32'h8000_1000;
    localparam logic [31:0] c_FROMHOST_ADDR_DFLT = 32'h8000_1040;

    function automatic logic is_terminal(input state_t s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/host_reg.sv
// ============================================================================
// Module  : host_reg
// Brief   : 32-bit byte-enabled register with synchronous reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module host_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  byte_en,
    input  logic [31:0] wdata,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 32'd0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    q[8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tohost_monitor.sv
// ============================================================================
// Module  : tohost_monitor
// Brief   : riscv-tests tohost/fromhost mailbox with PASS/FAIL/TIMEOUT FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tohost_monitor
    import tohost_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR   = c_TOHOST_ADDR_DFLT,
    parameter logic [31:0] FROMHOST_ADDR = c_FROMHOST_ADDR_DFLT,
    parameter int unsigned MAX_TICKS     = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dmem_addr_i,
    input  logic        dmem_read_i,
    input  logic [3:0]  dmem_wsel_byte_i,
    input  logic [31:0] dmem_wdata_i,
    output logic [31:0] dmem_rdata_o,
    output logic        hit_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [30:0] fail_code_o,
    output logic [31:0] cycle_count_o
);

    localparam logic [31:0] c_TIMEOUT_AT = MAX_TICKS - 1;

    logic        w_sel_to;
    logic        w_sel_from;
    logic        w_write;
    logic [3:0]  w_to_be;
    logic [3:0]  w_from_be;
    logic [31:0] r_tohost;
    logic [31:0] r_fromhost;
    logic [31:0] r_rdata;
    logic        r_eval_pending;
    state_t      r_state;
    state_t      w_next_state;
    logic        w_eval;
    logic        w_capture_fail;
    logic [31:0] r_cycle_count;
    logic [30:0] r_fail_code;
    logic        r_done;
    logic        r_pass;
    logic        r_timeout;
    logic        w_unused_addr_lsb;

    // Word decode: byte offset within the word does not matter.
    assign w_sel_to          = (dmem_addr_i[31:2] == TOHOST_ADDR[31:2]);
    assign w_sel_from        = (dmem_addr_i[31:2] == FROMHOST_ADDR[31:2]);
    assign w_unused_addr_lsb = ^dmem_addr_i[1:0];
    assign w_write           = |dmem_wsel_byte_i;
    assign hit_o             = (w_sel_to | w_sel_from) & (dmem_read_i | w_write);
    assign w_to_be           = w_sel_to   ? dmem_wsel_byte_i : 4'b0000;
    assign w_from_be         = w_sel_from ? dmem_wsel_byte_i : 4'b0000;

    host_reg u_tohost (
        .clk     (clk_i),
        .rst     (rst_i),
        .byte_en (w_to_be),
        .wdata   (dmem_wdata_i),
        .q       (r_tohost)
    );

    host_reg u_fromhost (
        .clk     (clk_i),
        .rst     (rst_i),
        .byte_en (w_from_be),
        .wdata   (dmem_wdata_i),
        .q       (r_fromhost)
    );

    // Reads sample the register before this cycle's write lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata        <= 32'd0;
            r_eval_pending <= 1'b0;
        end else begin
            r_eval_pending <= |w_to_be;
            if (dmem_read_i && w_sel_to) begin
                r_rdata <= r_tohost;
            end else if (dmem_read_i && w_sel_from) begin
                r_rdata <= r_fromhost;
            end else begin
                r_rdata <= 32'd0;
            end
        end
    end

    assign w_eval = (r_state == ST_RUN) && r_eval_pending;

    always_comb begin
        w_next_state   = r_state;
        w_capture_fail = 1'b0;
        case (r_state)
            ST_IDLE: w_next_state = ST_RUN;
            ST_RUN: begin
                if (w_eval && (r_tohost == 32'd1)) begin
                    w_next_state = ST_PASS;
                end else if (w_eval && r_tohost[0]) begin
                    w_next_state   = ST_FAIL;
                    w_capture_fail = 1'b1;
                end else if (r_cycle_count == c_TIMEOUT_AT) begin
                    w_next_state = ST_TIMEOUT;
                end
            end
            default: w_next_state = r_state;
        endcase
    end

    // The counter only advances on cycles that remain in RUN, so it freezes
    // on the value seen when the terminating decision was made.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_cycle_count <= 32'd0;
            r_fail_code   <= 31'd0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_capture_fail) begin
                r_fail_code <= r_tohost[31:1];
            end
            if ((r_state == ST_RUN) && (w_next_state == ST_RUN) &&
                (r_cycle_count != 32'hFFFF_FFFF)) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            r_done    <= is_terminal(w_next_state);
            r_pass    <= (w_next_state == ST_PASS);
            r_timeout <= (w_next_state == ST_TIMEOUT);
        end
    end

    assign dmem_rdata_o  = r_rdata;
    assign done_o        = r_done;
    assign pass_o        = r_pass;
    assign timeout_o     = r_timeout;
    assign fail_code_o   = r_fail_code;
    assign cycle_count_o = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_tohost_monitor.sv
// ============================================================================
// Module  : tb_tohost_monitor
// Brief   : Self-checking bench for tohost_monitor (default and 20-tick units).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tohost_monitor;

    localparam logic [31:0] TO_A   = 32'h8000_1000;
    localparam logic [31:0] FROM_A = 32'h8000_1040;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        rd;
    logic [3:0]  wsel;
    logic [31:0] wdata;

    logic [31:0] rdata_a, cnt_a, rdata_b, cnt_b;
    logic        hit_a, done_a, pass_a, timeout_a;
    logic        hit_b, done_b, pass_b, timeout_b;
    logic [30:0] fail_a, fail_b;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [3:0]  wsel;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] exp_q[$];

    tohost_monitor u_dut (
        .clk_i(clk), .rst_i(rst), .dmem_addr_i(addr), .dmem_read_i(rd),
        .dmem_wsel_byte_i(wsel), .dmem_wdata_i(wdata), .dmem_rdata_o(rdata_a),
        .hit_o(hit_a), .done_o(done_a), .pass_o(pass_a), .timeout_o(timeout_a),
        .fail_code_o(fail_a), .cycle_count_o(cnt_a)
    );

    tohost_monitor #(.MAX_TICKS(20)) u_dut20 (
        .clk_i(clk), .rst_i(rst), .dmem_addr_i(addr), .dmem_read_i(rd),
        .dmem_wsel_byte_i(wsel), .dmem_wdata_i(wdata), .dmem_rdata_o(rdata_b),
        .hit_o(hit_b), .done_o(done_b), .pass_o(pass_b), .timeout_o(timeout_b),
        .fail_code_o(fail_b), .cycle_count_o(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic idle_bus();
        addr  = 32'd0;
        rd    = 1'b0;
        wsel  = 4'b0000;
        wdata = 32'd0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rdata_a"},   rdata_a, 32'd0);
        chk({tag, " done_a"},    {31'd0, done_a}, 32'd0);
        chk({tag, " pass_a"},    {31'd0, pass_a}, 32'd0);
        chk({tag, " timeout_a"}, {31'd0, timeout_a}, 32'd0);
        chk({tag, " fail_a"},    {1'b0, fail_a}, 32'd0);
        chk({tag, " cnt_a"},     cnt_a, 32'd0);
        chk({tag, " rdata_b"},   rdata_b, 32'd0);
        chk({tag, " done_b"},    {31'd0, done_b}, 32'd0);
        chk({tag, " pass_b"},    {31'd0, pass_b}, 32'd0);
        chk({tag, " timeout_b"}, {31'd0, timeout_b}, 32'd0);
        chk({tag, " fail_b"},    {1'b0, fail_b}, 32'd0);
        chk({tag, " cnt_b"},     cnt_b, 32'd0);
    endtask

    // Leaves rst low just after the last reset edge; the next edge is the IDLE cycle.
    task automatic do_reset();
        rst = 1'b1;
        idle_bus();
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr = a; wsel = be; wdata = d; rd = 1'b0;
        tick();
        idle_bus();
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; rd = 1'b1; wsel = 4'b0000;
        exp_q.push_back(exp);
        tick();
        idle_bus();
        chk(name, rdata_a, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp;

        vecs[0]  = '{FROM_A,           1'b0, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0};
        vecs[1]  = '{32'h8000_1042,    1'b1, 4'h0, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{FROM_A,           1'b1, 4'h8, 32'h1122_3344, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{FROM_A,           1'b1, 4'h0, 32'h0,         1'b1, 32'h11AD_BEEF};
        vecs[4]  = '{32'h8000_1044,    1'b1, 4'h0, 32'h0,         1'b0, 32'h0};
        vecs[5]  = '{32'h8000_0FFC,    1'b1, 4'hF, 32'h1234_5678, 1'b0, 32'h0};
        vecs[6]  = '{TO_A,             1'b1, 4'h0, 32'h0,         1'b1, 32'h0};
        vecs[7]  = '{TO_A,             1'b0, 4'h6, 32'hAABB_CCDE, 1'b1, 32'h0};
        vecs[8]  = '{32'h8000_1003,    1'b1, 4'h0, 32'h0,         1'b1, 32'h00BB_CC00};
        vecs[9]  = '{FROM_A,           1'b0, 4'h0, 32'h0,         1'b0, 32'h0};
        vecs[10] = '{FROM_A,           1'b1, 4'h4, 32'h0055_0000, 1'b1, 32'h11AD_BEEF};
        vecs[11] = '{FROM_A,           1'b1, 4'h0, 32'h0,         1'b1, 32'h1155_BEEF};

        rst = 1'b1;
        idle_bus();
        do_reset();
        chk_reset_outputs("reset");

        // Register access table
        tick();
        for (int i = 0; i < 12; i++) begin
            addr = vecs[i].addr; rd = vecs[i].rd;
            wsel = vecs[i].wsel; wdata = vecs[i].wdata;
            #1;
            chk($sformatf("hit_a[%0d]", i), {31'd0, hit_a}, {31'd0, vecs[i].exp_hit});
            chk($sformatf("hit_b[%0d]", i), {31'd0, hit_b}, {31'd0, vecs[i].exp_hit});
            exp_q.push_back(vecs[i].exp_rdata);
            tick();
            idle_bus();
            exp = exp_q.pop_front();
            chk($sformatf("rdata_a[%0d]", i), rdata_a, exp);
            chk($sformatf("rdata_b[%0d]", i), rdata_b, exp);
        end
        tick();
        chk("table done_a", {31'd0, done_a}, 32'd0);

        // Reset while in PASS; the write in the reset cycle must be dropped
        write(TO_A, 4'hF, 32'h1);
        tick();
        chk("pre-rst pass_a", {31'd0, pass_a}, 32'd1);
        rst = 1'b1; addr = FROM_A; wsel = 4'hF; wdata = 32'hCAFE_F00D;
        tick();
        chk_reset_outputs("rst in PASS");
        rst = 1'b0;
        idle_bus();
        tick();
        chk("resume cnt R0", cnt_a, 32'd0);
        read_chk("fromhost after rst", FROM_A, 32'd0);
        ticks(2);
        chk("resume cnt R3", cnt_a, 32'd3);
        chk("resume done_a", {31'd0, done_a}, 32'd0);

        // PASS on full write at cycle 50
        do_reset();
        ticks(50);
        write(TO_A, 4'hF, 32'h1);
        chk("pass50 done early", {31'd0, done_a}, 32'd0);
        tick();
        chk("pass50 done",  {31'd0, done_a}, 32'd1);
        chk("pass50 pass",  {31'd0, pass_a}, 32'd1);
        chk("pass50 cnt",   cnt_a, 32'd50);
        ticks(5);
        chk("pass50 cnt frozen", cnt_a, 32'd50);
        chk("pass50 fail",  {1'b0, fail_a}, 32'd0);

        // FAIL code capture and stickiness
        do_reset();
        ticks(5);
        write(TO_A, 4'hF, 32'h7);
        tick();
        chk("fail done",    {31'd0, done_a}, 32'd1);
        chk("fail pass",    {31'd0, pass_a}, 32'd0);
        chk("fail timeout", {31'd0, timeout_a}, 32'd0);
        chk("fail code",    {1'b0, fail_a}, 32'd3);
        chk("fail code b",  {1'b0, fail_b}, 32'd3);
        write(TO_A, 4'hF, 32'h1);
        tick();
        chk("fail sticky pass", {31'd0, pass_a}, 32'd0);
        chk("fail sticky code", {1'b0, fail_a}, 32'd3);
        read_chk("tohost after sticky write", TO_A, 32'd1);

        // Byte-lane writes: 0x00 keeps running, 0x01 passes
        do_reset();
        ticks(2);
        write(TO_A, 4'b0001, 32'hAABB_CC00);
        tick();
        chk("byte0 done", {31'd0, done_a}, 32'd0);
        read_chk("byte0 tohost", TO_A, 32'd0);
        write(TO_A, 4'b0001, 32'h5566_7701);
        tick();
        chk("byte1 pass", {31'd0, pass_a}, 32'd1);
        read_chk("byte1 tohost", TO_A, 32'd1);

        // Timeout with MAX_TICKS=20
        do_reset();
        ticks(20);
        chk("to early flag", {31'd0, timeout_b}, 32'd0);
        chk("to early cnt",  cnt_b, 32'd19);
        tick();
        chk("to flag",   {31'd0, timeout_b}, 32'd1);
        chk("to done",   {31'd0, done_b}, 32'd1);
        chk("to pass",   {31'd0, pass_b}, 32'd0);
        chk("to cnt",    cnt_b, 32'd19);
        ticks(3);
        chk("to cnt frozen", cnt_b, 32'd19);
        chk("to a running",  {31'd0, done_a}, 32'd0);

        // Evaluation coinciding with timeout wins
        do_reset();
        ticks(19);
        write(TO_A, 4'hF, 32'h1);
        chk("race done early", {31'd0, done_b}, 32'd0);
        chk("race cnt early",  cnt_b, 32'd19);
        tick();
        chk("race pass",    {31'd0, pass_b}, 32'd1);
        chk("race timeout", {31'd0, timeout_b}, 32'd0);
        chk("race cnt",     cnt_b, 32'd19);
        chk("race pass_a",  {31'd0, pass_a}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
